// File: rtl/phase_frame_scheduler.sv
// Frame scheduler: walks a WIDTH x HEIGHT frame, fetches each pixel's phase from memory and
// presents it to a display sink. Optional macro PHASE_ROTATE_EN adds a rot_offset input.
module phase_frame_scheduler #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned HEIGHT = 48,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_phase,
`ifdef PHASE_ROTATE_EN
    input  logic [15:0]       rot_offset,
`endif
    output logic [15:0]       phase_out,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [15:0]       pix_x,
    output logic [15:0]       pix_y,
    output logic              sof,
    output logic              eol,
    output logic              eof
);

    localparam logic [15:0] XLast = 16'(WIDTH - 1);
    localparam logic [15:0] YLast = 16'(HEIGHT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StPresent, StDone} state_e;

    state_e              state_q;
    logic                busy_q, done_q, mem_req_q, pix_valid_q;
    logic                sof_q, eol_q, eof_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [15:0]         phase_q, x_q, y_q;
    logic [15:0]         phase_capture;

`ifdef PHASE_ROTATE_EN
    assign phase_capture = mem_phase + rot_offset;
`else
    assign phase_capture = mem_phase;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            phase_q     <= '0;
            pix_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StReq;
                        busy_q     <= 1'b1;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= '0;
                        x_q        <= '0;
                        y_q        <= '0;
                    end
                end
                StReq: begin
                    // abort wins over a coincident ack, so the phase is not captured
                    if (abort) begin
                        state_q   <= StIdle;
                        busy_q    <= 1'b0;
                        mem_req_q <= 1'b0;
                    end else if (mem_ack) begin
                        state_q     <= StPresent;
                        phase_q     <= phase_capture;
                        mem_req_q   <= 1'b0;
                        pix_valid_q <= 1'b1;
                        sof_q       <= (x_q == '0) && (y_q == '0);
                        eol_q       <= (x_q == XLast);
                        eof_q       <= (x_q == XLast) && (y_q == YLast);
                    end
                end
                StPresent: begin
                    if (abort) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        pix_valid_q <= 1'b0;
                        sof_q       <= 1'b0;
                        eol_q       <= 1'b0;
                        eof_q       <= 1'b0;
                    end else if (pix_ready) begin
                        pix_valid_q <= 1'b0;
                        sof_q       <= 1'b0;
                        eol_q       <= 1'b0;
                        eof_q       <= 1'b0;
                        if (eof_q) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= StReq;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= mem_addr_q + ADDR_W'(1);
                            if (eol_q) begin
                                x_q <= '0;
                                y_q <= y_q + 16'd1;
                            end else begin
                                x_q <= x_q + 16'd1;
                            end
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign phase_out = phase_q;
    assign pix_valid = pix_valid_q;
    assign pix_x     = x_q;
    assign pix_y     = y_q;
    assign sof       = sof_q;
    assign eol       = eol_q;
    assign eof       = eof_q;

endmodule

// File: doc/phase_frame_scheduler.md
PHASE_FRAME_SCHEDULER -- requirements
Module: phase_frame_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 64, pixels per line (>=2).
REQ-002 SHALL have parameter HEIGHT, default 48, lines per frame (>=2).
REQ-003 SHALL have parameter ADDR_W, default 12, phase-memory address width (2^ADDR_W >= WIDTH*HEIGHT).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  frame start request, sampled in IDLE only.
REQ-007 SHALL have port abort  input  1  cancel frame in progress.
REQ-008 SHALL have port busy  output  1  high in any state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-010 SHALL have port mem_req  output  1  phase-memory read request.
REQ-011 SHALL have port mem_addr  output  ADDR_W  read address, y*WIDTH+x.
REQ-012 SHALL have port mem_ack  input  1  read data valid on mem_phase.
REQ-013 SHALL have port mem_phase  input  16  phase sample, 0 = -pi, 65535 = +pi.
REQ-014 SHALL have port phase_out  output  16  registered phase driving the external phase-to-colour converter.
REQ-015 SHALL have ports pix_valid output 1 / pix_ready input 1  pixel handshake to display sink.
REQ-016 SHALL have ports pix_x output 16, pix_y output 16  coordinates of presented pixel.
REQ-017 SHALL have ports sof, eol, eof  output  1 each  first pixel of frame, last pixel of line, last pixel of frame; valid only with pix_valid.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, PRESENT, DONE.
REQ-019 IDLE: start=1 -> REQ next cycle, x=y=0, mem_addr=0.
REQ-020 REQ: mem_req=1, mem_addr stable; mem_ack=1 same cycle -> capture mem_phase into phase_out, go PRESENT; else remain.
REQ-021 PRESENT: pix_valid=1; phase_out, pix_x, pix_y, sof/eol/eof stable until pix_valid&&pix_ready.
REQ-022 On handshake, not last pixel: advance x; x==WIDTH-1 wraps x to 0, increments y; mem_addr increments by 1 (incremental, no multiplier); -> REQ.
REQ-023 On handshake at x==WIDTH-1, y==HEIGHT-1 -> DONE; DONE asserts done for exactly one cycle, then IDLE.
REQ-024 Minimum throughput 2 cycles/pixel (ack in REQ first cycle, ready in PRESENT first cycle).
REQ-025 mem_ack outside REQ SHALL be ignored; pix_ready outside PRESENT SHALL be ignored.
REQ-026 start while busy SHALL be ignored; start in DONE cycle SHALL be ignored.
REQ-027 abort in REQ or PRESENT -> IDLE next cycle, mem_req and pix_valid low, no done pulse; abort has priority over mem_ack and pix_ready same cycle; abort in IDLE/DONE ignored.
REQ-028 sof=1 iff x==0,y==0; eol=1 iff x==WIDTH-1; eof=1 iff eol and y==HEIGHT-1.

Reset
REQ-029 rst=1 SHALL force IDLE next edge regardless of state, including mid-frame; no done pulse.
REQ-030 Reset values: busy=0, done=0, mem_req=0, mem_addr=0, phase_out=0, pix_valid=0, pix_x=0, pix_y=0, sof=eol=eof=0.
REQ-031 rst SHALL have priority over start and abort.

Configuration
REQ-032 Macro PHASE_ROTATE_EN SHALL, when defined, add input rot_offset (16 bits) and make phase_out = mem_phase + rot_offset modulo 2^16, rot_offset sampled at the mem_ack capture cycle.
REQ-033 Without PHASE_ROTATE_EN, rot_offset port SHALL not exist and phase_out = mem_phase unmodified.

Verification (WIDTH=4, HEIGHT=2, ADDR_W=3)
REQ-034 start pulse, mem_ack and pix_ready tied 1 -> 8 pixels, addresses 0..7, 16 cycles REQ/PRESENT, done pulse one cycle after 8th handshake, sof on pixel 0, eol on x=3, eof on pixel 7.
REQ-035 mem_ack delayed 3 cycles on addr 2 -> mem_req held 4 cycles, mem_addr=2 stable, phase_out = captured 0x1234 only after ack.
REQ-036 pix_ready low 5 cycles on pixel (1,0) -> pix_valid, phase_out, pix_x=1, pix_y=0 stable all 5 cycles; no new mem_req.
REQ-037 abort asserted same cycle as mem_ack at addr 5 -> IDLE next cycle, phase_out unchanged, no done; subsequent start restarts at addr 0.
REQ-038 rst asserted in PRESENT of pixel (2,1) -> all outputs reset values next cycle; with PHASE_ROTATE_EN, rot_offset=0x8000, mem_phase=0x9000 -> phase_out=0x1000.
